// File: rtl/simon_pkg.sv
// Shared types and constants for the multi-player Simon controller.
// Mode LED encodings and the width helper are used by the top and the turn arbiter.
package simon_pkg;

    typedef enum logic [2:0] {
        S_INPUT,
        S_PLAYBACK,
        S_REPEAT,
        S_WIN,
        S_DONE
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_WIN      = 3'b110;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

    // Width of a counter/index holding values 0..n-1, never narrower than one bit.
    function automatic int width_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simon_rr_next.sv
// Round-robin turn arbiter: next alive player after the current one, wrapping.
// Returns the current player when nobody else is alive; also flags an alive count <= 1.
module simon_rr_next
    import simon_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int PW          = width_min1(NUM_PLAYERS)
) (
    input  logic [PW-1:0]          player_i,
    input  logic [NUM_PLAYERS-1:0] alive_i,
    output logic [PW-1:0]          next_o,
    output logic                   last_o
);

    int cand;

    always_comb begin
        next_o = player_i;
        cand   = 0;
        // Walk offsets from farthest to nearest so the nearest alive player wins.
        for (int k = NUM_PLAYERS - 1; k >= 1; k--) begin
            cand = (int'(player_i) + k) % NUM_PLAYERS;
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j == cand && alive_i[j]) begin
                    next_o = PW'(j);
                end
            end
        end
    end

    assign last_o = ($countones(alive_i) <= 1);

endmodule

// File: rtl/simon_control_mp.sv
// Multi-player Simon controller: entry capture, timed playback, repeat with timeout,
// round-robin turns with elimination, and terminal WIN/DONE states.
module simon_control_mp
    import simon_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int NUM_PLAYERS    = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int AW             = $clog2(DEPTH),
    parameter int CW             = $clog2(DEPTH + 1),
    parameter int PW             = width_min1(NUM_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pattern_valid,
    input  logic                   guess_valid,
    input  logic                   pattern_eq_mem,
    output logic                   w_en,
    output logic [AW-1:0]          mem_addr,
    output logic                   disp_mem,
    output logic [CW-1:0]          count,
    output logic [PW-1:0]          player,
    output logic [NUM_PLAYERS-1:0] alive,
    output logic                   load_level,
    output logic [2:0]             mode_leds
);

    localparam int HW = width_min1(HOLD_CYCLES);
    localparam int TW = width_min1(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [NUM_PLAYERS-1:0] ONE_HOT0 = NUM_PLAYERS'(1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [PW-1:0]          player_q, player_d;
    logic [NUM_PLAYERS-1:0] alive_q, alive_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic [NUM_PLAYERS-1:0] alive_wo_cur;
    logic [PW-1:0]          rr_next;
    logic                   rr_last;
    logic                   idx_not_last, hold_last, tmo_expire, hit, miss;

    // The arbiter sees the mask without the current player: that is the post-miss
    // mask, and it never changes the "next other player" answer used after INPUT.
    assign alive_wo_cur = alive_q & ~(ONE_HOT0 << player_q);

    simon_rr_next #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .PW         (PW)
    ) u_rr_next (
        .player_i(player_q),
        .alive_i (alive_wo_cur),
        .next_o  (rr_next),
        .last_o  (rr_last)
    );

    assign idx_not_last = (CW'(idx_q) + 1'b1) < count_q;
    assign hold_last    = (int'(hold_q) == HOLD_CYCLES - 1);
    assign tmo_expire   = TMO_EN && (int'(tmo_q) == TIMEOUT_CYCLES - 1);
    assign hit          = guess_valid && pattern_eq_mem;
    assign miss         = guess_valid ? !pattern_eq_mem : tmo_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INPUT;
            count_q  <= '0;
            idx_q    <= '0;
            player_q <= '0;
            alive_q  <= '1;
            hold_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            player_q <= player_d;
            alive_q  <= alive_d;
            hold_q   <= hold_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        player_d = player_q;
        alive_d  = alive_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            S_INPUT: begin
                if (pattern_valid) begin
                    count_d  = count_q + 1'b1;
                    idx_d    = '0;
                    hold_d   = '0;
                    player_d = rr_next;
                    state_d  = S_PLAYBACK;
                end
            end
            S_PLAYBACK: begin
                if (!hold_last) begin
                    hold_d = hold_q + 1'b1;
                end else if (idx_not_last) begin
                    idx_d  = idx_q + 1'b1;
                    hold_d = '0;
                end else begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = S_REPEAT;
                end
            end
            S_REPEAT: begin
                if (hit) begin
                    if (idx_not_last) begin
                        idx_d = idx_q + 1'b1;
                        tmo_d = '0;
                    end else if (count_q == CW'(DEPTH)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_INPUT;
                    end
                end else if (miss) begin
                    alive_d = alive_wo_cur;
                    if (rr_last) begin
                        state_d = S_DONE;
                    end else begin
                        player_d = rr_next;
                        idx_d    = '0;
                        hold_d   = '0;
                        state_d  = S_PLAYBACK;
                    end
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_en      = 1'b0;
        mem_addr  = idx_q;
        disp_mem  = 1'b0;
        mode_leds = LED_MODE_INPUT;
        unique case (state_q)
            S_INPUT: begin
                mem_addr = AW'(count_q);
                w_en     = pattern_valid & ~rst;
            end
            S_PLAYBACK: begin
                disp_mem  = 1'b1;
                mode_leds = LED_MODE_PLAYBACK;
            end
            S_REPEAT: mode_leds = LED_MODE_REPEAT;
            S_WIN:    mode_leds = LED_MODE_WIN;
            S_DONE:   mode_leds = LED_MODE_DONE;
            default:  ;
        endcase
    end

    assign count      = count_q;
    assign player     = player_q;
    assign alive      = alive_q;
    assign load_level = rst;

endmodule

// File: tb/tb_simon_control_mp.sv
// Bench for simon_control_mp: a 3-player game model tracked every cycle, plus a
// 1-player instance checked against hand-computed values.
module tb_simon_control_mp;

    localparam int DEPTH = 2;
    localparam int NP    = 3;
    localparam int HOLD  = 3;
    localparam int TMO   = 4;

    localparam int ST_IN = 0, ST_PB = 1, ST_RP = 2, ST_WIN = 3, ST_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance: DEPTH=2, 3 players, 3-cycle hold, 4-cycle timeout.
    logic       pattern_valid = 1'b0, guess_valid = 1'b0, pattern_eq_mem = 1'b0;
    logic       w_en, disp_mem, load_level;
    logic [0:0] mem_addr;
    logic [1:0] count;
    logic [1:0] player;
    logic [2:0] alive;
    logic [2:0] mode_leds;

    // Second instance: single player, 1-cycle hold, no timeout, DEPTH=16.
    logic       pv1 = 1'b0, gv1 = 1'b0, eq1 = 1'b0;
    logic       w_en1, disp_mem1, load_level1;
    logic [3:0] mem_addr1;
    logic [4:0] count1;
    logic [0:0] player1;
    logic [0:0] alive1;
    logic [2:0] mode_leds1;

    int n_checks = 0;
    int n_pass   = 0;

    simon_control_mp #(
        .DEPTH(DEPTH), .NUM_PLAYERS(NP), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .pattern_valid(pattern_valid), .guess_valid(guess_valid), .pattern_eq_mem(pattern_eq_mem),
        .w_en(w_en), .mem_addr(mem_addr), .disp_mem(disp_mem), .count(count),
        .player(player), .alive(alive), .load_level(load_level), .mode_leds(mode_leds)
    );

    simon_control_mp #(
        .DEPTH(16), .NUM_PLAYERS(1), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .pattern_valid(pv1), .guess_valid(gv1), .pattern_eq_mem(eq1),
        .w_en(w_en1), .mem_addr(mem_addr1), .disp_mem(disp_mem1), .count(count1),
        .player(player1), .alive(alive1), .load_level(load_level1), .mode_leds(mode_leds1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model of the 3-player game ----------------
    int         m_st     = ST_IN;
    int         m_count  = 0;
    int         m_step   = 0;   // cycles spent in the current playback pass
    int         m_idx    = 0;   // position being repeated
    int         m_idle   = 0;   // idle cycles at the current repeat position
    int         m_player = 0;
    logic [NP-1:0] m_alive = '1;
    int         led_tbl[5] = '{1, 2, 4, 6, 7};

    function automatic int next_alive(input int p, input logic [NP-1:0] a);
        for (int k = 1; k < NP; k++)
            if (a[(p + k) % NP]) return (p + k) % NP;
        return p;
    endfunction

    task automatic model_step();
        case (m_st)
            ST_IN: if (pattern_valid) begin
                m_count++;
                m_player = next_alive(m_player, m_alive);
                m_step = 0;
                m_st = ST_PB;
            end
            ST_PB: begin
                m_step++;
                if (m_step == m_count * HOLD) begin
                    m_st = ST_RP; m_idx = 0; m_idle = 0;
                end
            end
            ST_RP: begin
                if (guess_valid && pattern_eq_mem) begin
                    if (m_idx + 1 < m_count) begin m_idx++; m_idle = 0; end
                    else if (m_count == DEPTH) m_st = ST_WIN;
                    else m_st = ST_IN;
                end else if (guess_valid || m_idle == TMO - 1) begin
                    m_alive[m_player] = 1'b0;
                    if ($countones(m_alive) <= 1) m_st = ST_DONE;
                    else begin
                        m_player = next_alive(m_player, m_alive);
                        m_step = 0;
                        m_st = ST_PB;
                    end
                end else begin
                    m_idle++;
                end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = ST_IN; m_count = 0; m_step = 0; m_idx = 0; m_idle = 0;
            m_player = 0; m_alive = '1;
        end else begin
            model_step();
        end
    end

    // Compare process: every cycle, away from the rising edge.
    initial forever begin
        @(negedge clk);
        #1;
        chk("mode_leds", mode_leds, led_tbl[m_st]);
        chk("disp_mem", disp_mem, (m_st == ST_PB));
        chk("count", count, m_count);
        chk("player", player, m_player);
        chk("alive", alive, m_alive);
        chk("load_level", load_level, rst);
        chk("w_en", w_en, (m_st == ST_IN) && pattern_valid && !rst);
        if (m_st == ST_IN)      chk("mem_addr_in", mem_addr, m_count);
        else if (m_st == ST_PB) chk("mem_addr_pb", mem_addr, m_step / HOLD);
        else if (m_st == ST_RP) chk("mem_addr_rp", mem_addr, m_idx);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit pv, input bit gv, input bit eq);
        @(negedge clk);
        pattern_valid = pv; guess_valid = gv; pattern_eq_mem = eq;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive1(input bit pv, input bit gv, input bit eq);
        @(negedge clk);
        pv1 = pv; gv1 = gv; eq1 = eq;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pattern_valid = 1'b0; guess_valid = 1'b0; pattern_eq_mem = 1'b0;
        pv1 = 1'b0; gv1 = 1'b0; eq1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [0:0] hold_exp[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- single player: one round, then a miss leaving nobody alive ----
        #2;
        chk("p1_reset_mode", mode_leds1, 3'b001);
        chk("p1_reset_alive", alive1, 1'b1);
        drive1(1, 0, 0); #2;
        chk("p1_wen", w_en1, 1'b1);
        chk("p1_waddr0", mem_addr1, 4'd0);
        drive1(0, 0, 0); #2;
        chk("p1_count1", count1, 5'd1);
        chk("p1_pb_mode", mode_leds1, 3'b010);
        drive1(0, 1, 1); #2;
        chk("p1_rp_mode", mode_leds1, 3'b100);
        drive1(0, 0, 0); #2;
        chk("p1_back_input", mode_leds1, 3'b001);
        drive1(1, 0, 0); #2;
        chk("p1_waddr1", mem_addr1, 4'd1);
        drive1(0, 0, 0); #2;
        chk("p1_pb_addr0", mem_addr1, 4'd0);
        drive1(0, 0, 0); #2;
        chk("p1_pb_addr1", mem_addr1, 4'd1);
        drive1(0, 1, 0); #2;
        chk("p1_rp_mode2", mode_leds1, 3'b100);
        drive1(0, 0, 0); #2;
        chk("p1_done_mode", mode_leds1, 3'b111);
        chk("p1_done_alive", alive1, 1'b0);
        chk("p1_done_count", count1, 5'd2);

        // ---- asynchronous reset in the middle of playback ----
        do_reset();
        drive(1, 0, 0);
        drive(0, 0, 0);
        #3;
        pattern_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mode", mode_leds, 3'b001);
        chk("rst_count", count, 2'd0);
        chk("rst_alive", alive, 3'b111);
        chk("rst_load_level", load_level, 1'b1);
        chk("rst_wen", w_en, 1'b0);
        pattern_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---- two correct rounds to WIN, with hold timing on the 2-entry playback ----
        drive(1, 0, 0); idle(3); drive(0, 1, 1);
        idle(1); #2;
        chk("win_r1_input", mode_leds, 3'b001);
        chk("win_r1_player", player, 2'd1);
        drive(1, 0, 0); #2;
        chk("win_wen", w_en, 1'b1);
        chk("win_waddr", mem_addr, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0); #2;
            chk("hold_addr", mem_addr, hold_exp[i]);
            chk("hold_disp", disp_mem, 1'b1);
        end
        drive(0, 1, 1);
        drive(0, 1, 1);
        drive(1, 1, 0); #2;
        chk("win_mode", mode_leds, 3'b110);
        drive(1, 1, 1);
        idle(1); #2;
        chk("win_sticky", mode_leds, 3'b110);
        chk("win_count", count, 2'd2);
        chk("win_player", player, 2'd2);

        // ---- wrong guesses eliminate players until one survives ----
        do_reset();
        drive(1, 0, 0); idle(3); drive(0, 1, 0);
        idle(1); #2;
        chk("miss1_alive", alive, 3'b101);
        chk("miss1_player", player, 2'd2);
        chk("miss1_mode", mode_leds, 3'b010);
        idle(2); drive(0, 1, 0);
        idle(1); #2;
        chk("done_mode", mode_leds, 3'b111);
        chk("done_alive", alive, 3'b001);
        chk("done_player", player, 2'd2);
        drive(1, 1, 0); idle(2); #2;
        chk("done_frozen", player, 2'd2);

        // ---- repeat timeout, then a guess on the expiry cycle ----
        do_reset();
        drive(1, 0, 0); idle(3);
        idle(5); #2;
        chk("tmo_alive", alive, 3'b101);
        chk("tmo_player", player, 2'd2);
        chk("tmo_mode", mode_leds, 3'b010);
        chk("tmo_idx", mem_addr, 1'b0);
        idle(2); idle(3); drive(0, 1, 1);
        idle(1); #2;
        chk("tmo_guess_mode", mode_leds, 3'b001);
        chk("tmo_guess_alive", alive, 3'b101);
        drive(1, 0, 0);
        idle(1); #2;
        chk("wrap_player", player, 2'd0);
        chk("wrap_count", count, 2'd2);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_control_mp.md
# simon_control_mp

Parametrised multi-player successor to the Simon game controller FSM. It integrates the pattern-count and playback-index counters and adds timed playback, a repeat timeout, round-robin turns with player elimination, and a WIN state at maximum depth. It sits between the switch/button front end and an external pattern memory with synchronous write and combinational read, which supplies `pattern_eq_mem`.

## Interface
- `DEPTH`, 16: maximum pattern length (≥2); `AW = $clog2(DEPTH)`, `CW = $clog2(DEPTH+1)`.
- `NUM_PLAYERS`, 2: number of players (1..8); `PW = max(1,$clog2(NUM_PLAYERS))`.
- `HOLD_CYCLES`, 1: cycles each playback entry is displayed (≥1).
- `TIMEOUT_CYCLES`, 0: idle cycles in REPEAT before a forced miss; 0 disables.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pattern_valid` in 1: switches hold a legal new entry (INPUT).
- `guess_valid` in 1: one-cycle strobe; a guess is presented (REPEAT).
- `pattern_eq_mem` in 1: switches equal `mem[mem_addr]`.
- `w_en` out 1: memory write strobe at `mem_addr`.
- `mem_addr` out AW: memory address.
- `disp_mem` out 1: LEDs show memory (1) or switches (0).
- `count` out CW: stored pattern length.
- `player` out PW: player whose turn it is.
- `alive` out NUM_PLAYERS: per-player still-in-game mask.
- `load_level` out 1: high while `rst` is high.
- `mode_leds` out 3: INPUT 001, PLAYBACK 010, REPEAT 100, WIN 110, DONE 111.

## Operation
- **Reset values:** state INPUT, `count` 0, index 0, `player` 0, `alive` all ones, hold and timeout counters 0, `w_en` 0 (forced low while `rst`), `disp_mem` 0, `mode_leds` 001.
- **INPUT:**
  - `mem_addr = count`; `w_en = pattern_valid`; `disp_mem` 0.
  - On `pattern_valid`: `count++`, index 0, hold 0, `player` becomes the next alive player after the current one (wrapping; unchanged if alone), go to PLAYBACK.
- **PLAYBACK:**
  - `mem_addr = index`; `disp_mem` 1.
  - The hold counter counts 0..HOLD_CYCLES-1.
  - At the terminal hold count: if `index < count-1`, then `index++` and hold is cleared; otherwise index 0, timeout 0, go to REPEAT.
- **REPEAT:**
  - `mem_addr = index`; `disp_mem` 0.
  - On `guess_valid` with `pattern_eq_mem` = 1:
    - if `index < count-1`: `index++` and timeout is cleared;
    - else if `count == DEPTH`: go to WIN;
    - else: go to INPUT (the same player adds the next entry).
  - Miss: `guess_valid` with `pattern_eq_mem` = 0, or the timeout counter reaching TIMEOUT_CYCLES-1 without `guess_valid` (when TIMEOUT_CYCLES > 0).
  - On a miss: clear `alive[player]`.
    - If at most 1 player remains alive afterwards: go to DONE.
    - Otherwise: `player` becomes the next alive player, index 0, hold 0, go to PLAYBACK (same sequence replayed).
  - `count` is unchanged by a miss.
- **WIN / DONE:** terminal until `rst`. `player` is frozen. In DONE the surviving player is the single set bit of `alive`. For NUM_PLAYERS = 1, a miss leaves `alive` = 0.
- **Boundaries:**
  - `pattern_valid` is ignored outside INPUT; `guess_valid` is ignored outside REPEAT.
  - `count` never exceeds DEPTH (WIN is reached first).
  - `guess_valid` and timeout expiry in the same cycle: the guess wins.
  - The next-alive search skips eliminated players and wraps from NUM_PLAYERS-1 to 0.

## Timing
- All state changes occur on the rising edge of `clk`.
- `rst` takes effect asynchronously: reset values appear immediately, mid-game included.
- `mode_leds`, `disp_mem`, `count`, `player`, `alive` are Moore outputs (registered state only).
- `w_en` and `mem_addr` are combinational from state and inputs. The memory captures data on the same edge on which the FSM leaves INPUT.
- Playback latency is `count*HOLD_CYCLES` cycles, from entering PLAYBACK to entering REPEAT.
- A guess is evaluated in the cycle in which `guess_valid` is high; the next state is visible one cycle later.

## Structure
- Package `simon_pkg`:
  - state enum (INPUT, PLAYBACK, REPEAT, WIN, DONE);
  - LED constants LED_MODE_INPUT/PLAYBACK/REPEAT/WIN/DONE;
  - a helper function computing the width max(1, $clog2(n)).
- Sub-module `simon_rr_next`: combinational, parametrised NUM_PLAYERS. Inputs: current player, alive mask. Outputs: next alive player, alive-count ≤ 1 flag.
- Single always_ff for state, counters, `player` and `alive`; one always_comb for outputs.

## Test plan
- **Reset mid-PLAYBACK:** assert `rst` (no clock) -> `mode_leds` 001, `count` 0, `alive` 2'b11, `load_level` 1, `w_en` 0.
- **Single-player round (NUM_PLAYERS=1, HOLD_CYCLES=1):**
  - `pattern_valid` + clock -> `w_en` 1 at `mem_addr` 0, then `count` 1, `mode_leds` 010;
  - one clock -> 100;
  - `guess_valid` & `pattern_eq_mem` -> 001.
- **Hold timing (HOLD_CYCLES=3, count=2):** PLAYBACK shows `mem_addr` 0 for 3 cycles, then 1 for 3 cycles, then REPEAT. `disp_mem` is 1 throughout.
- **Two-player miss:**
  - P0 inputs, so `player` becomes 1;
  - P1 guesses wrong -> `alive` 2'b01, `mode_leds` 111, `player` frozen.
- **Timeout (TIMEOUT_CYCLES=4, NUM_PLAYERS=3):**
  - idle REPEAT for 4 cycles -> `alive` bit cleared, next alive player, back to PLAYBACK with index 0;
  - `guess_valid` on the expiry cycle instead -> no elimination.
- **WIN (DEPTH=2):**
  - two complete correct rounds -> after the final correct guess at index 1, `mode_leds` 110;
  - further `pattern_valid`/`guess_valid` ignored.
